// File: rtl/axi_main_pkg.sv
// Shared widths, burst/response encodings and FSM state types for axi_main.
package axi_main_pkg;

  localparam int ADDR_W = 13;
  localparam int WORD_W = 16;
  localparam int AXI_AW = 32;
  localparam int AXI_DW = 64;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rd_state_t;

  // WRAP behaves like INCR; the word address wraps naturally at the RAM depth.
  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] addr,
                                                  input logic [1:0] burst);
    if (burst == BURST_INCR || burst == BURST_WRAP)
      return addr + ADDR_W'(1);
    else
      return addr;
  endfunction

endpackage

// File: rtl/axi_main_if.sv
// AXI4 write/read channel bundle between the host (master) and axi_main (slave).
interface axi_main_if;
  import axi_main_pkg::*;

  logic              awvalid;
  logic              awready;
  logic [AXI_AW-1:0] awaddr;
  logic [3:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic              wvalid;
  logic              wready;
  logic [AXI_DW-1:0] wdata;
  logic [7:0]        wstrb;
  logic              wlast;

  logic              bvalid;
  logic              bready;
  logic [1:0]        bresp;

  logic              arvalid;
  logic              arready;
  logic [AXI_AW-1:0] araddr;
  logic [3:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [AXI_DW-1:0] rdata;
  logic              rlast;
  logic [1:0]        rresp;

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bresp,
    input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rlast, rresp,
    input  rready
  );

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bresp,
    output bready,
    output arvalid, araddr, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rlast, rresp,
    output rready
  );

endinterface

// File: rtl/axi_main_ram.sv
// Single-port word RAM: synchronous write, registered read held until the next read enable.
module axi_main_ram
  import axi_main_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Array contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we)
      mem[addr] <= wdata;
  end

  // Read register only updates on re, so it stays stable while a beat waits on rready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (re)
      rdata <= mem[addr];
  end

endmodule

// File: rtl/axi_main.sv
// AXI4 slave with independent write and read FSMs sharing one single-port RAM.
module axi_main
  import axi_main_pkg::*;
(
  input logic       a_clk,
  input logic       a_rst_n,
  axi_main_if.slave bus
);

  wr_state_t         wr_state;
  logic [ADDR_W-1:0] wr_addr;
  logic [3:0]        wr_len;
  logic [1:0]        wr_burst;
  logic [4:0]        wr_beat;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [1:0]        bresp_q;

  rd_state_t         rd_state;
  logic [ADDR_W-1:0] rd_addr;
  logic [3:0]        rd_len;
  logic [1:0]        rd_burst;
  logic [3:0]        rd_beat;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;

  logic              wr_fire;
  logic              ram_we;
  logic              ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_dout;
  logic              unused_bits;

  assign wr_fire  = (wr_state == W_DATA) && bus.wvalid && wready_q;
  assign ram_we   = wr_fire && (wr_beat <= {1'b0, wr_len});
  assign ram_re   = (rd_state == R_FETCH) && !ram_we;
  assign ram_addr = ram_we ? wr_addr : rd_addr;

  assign bus.awready = awready_q;
  assign bus.wready  = wready_q;
  assign bus.bvalid  = bvalid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = arready_q;
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rresp   = RESP_OKAY;
  assign bus.rdata   = {{(AXI_DW-WORD_W){1'b0}}, ram_dout};

  assign unused_bits = ^{bus.awaddr[AXI_AW-1:ADDR_W], bus.awsize, bus.wdata[AXI_DW-1:WORD_W],
                         bus.wstrb, bus.araddr[AXI_AW-1:ADDR_W], bus.arsize};

  axi_main_ram u_ram (
    .clk   (a_clk),
    .rst_n (a_rst_n),
    .we    (ram_we),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (bus.wdata[WORD_W-1:0]),
    .rdata (ram_dout)
  );

  // Write FSM: accept AW, stream W beats into RAM, then report the response.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_state  <= W_IDLE;
      wr_addr   <= '0;
      wr_len    <= '0;
      wr_burst  <= BURST_FIXED;
      wr_beat   <= '0;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (bus.awvalid && awready_q) begin
            wr_addr   <= bus.awaddr[ADDR_W-1:0];
            wr_len    <= bus.awlen;
            wr_burst  <= bus.awburst;
            wr_beat   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            wr_state  <= W_DATA;
          end
        end
        W_DATA: begin
          if (wr_fire) begin
            wr_addr <= next_addr(wr_addr, wr_burst);
            if (wr_beat != 5'd31)
              wr_beat <= wr_beat + 5'd1;
            if (bus.wlast) begin
              wready_q <= 1'b0;
              bvalid_q <= 1'b1;
              bresp_q  <= (wr_beat == {1'b0, wr_len}) ? RESP_OKAY : RESP_SLVERR;
              wr_state <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (bus.bready) begin
            bvalid_q  <= 1'b0;
            awready_q <= 1'b1;
            wr_state  <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Read FSM: fetch one word per beat, yielding the RAM to a concurrent write beat.
  always_ff @(posedge a_clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      rd_state  <= R_IDLE;
      rd_addr   <= '0;
      rd_len    <= '0;
      rd_burst  <= BURST_FIXED;
      rd_beat   <= '0;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          if (bus.arvalid && arready_q) begin
            rd_addr   <= bus.araddr[ADDR_W-1:0];
            rd_len    <= bus.arlen;
            rd_burst  <= bus.arburst;
            rd_beat   <= '0;
            arready_q <= 1'b0;
            rd_state  <= R_FETCH;
          end
        end
        R_FETCH: begin
          if (!ram_we) begin
            rvalid_q <= 1'b1;
            rlast_q  <= (rd_beat == rd_len);
            rd_state <= R_DATA;
          end
        end
        R_DATA: begin
          if (bus.rready) begin
            rvalid_q <= 1'b0;
            rlast_q  <= 1'b0;
            if (rlast_q) begin
              arready_q <= 1'b1;
              rd_state  <= R_IDLE;
            end else begin
              rd_addr  <= next_addr(rd_addr, rd_burst);
              rd_beat  <= rd_beat + 4'd1;
              rd_state <= R_FETCH;
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_main.sv
// Directed bench for axi_main: scoreboard of expected read words built from a write model.
module tb_axi_main;

  logic clk;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  logic [15:0] model [int];
  logic [15:0] exp_q [$];
  logic [15:0] wr_buf [8];

  axi_main_if bus ();

  axi_main dut (
    .a_clk   (clk),
    .a_rst_n (rst_n),
    .bus     (bus)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case a handshake never resolves.
  initial begin
    #400000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int s);
    case (s)
      0:       return bus.awready;
      1:       return bus.wready;
      2:       return bus.bvalid;
      3:       return bus.arready;
      4:       return bus.rvalid;
      default: return 1'b0;
    endcase
  endfunction

  // Waits (at negedges) until the selected handshake signal is high, bounded to 50 cycles.
  task automatic wait_sig(input int s, input string tag, output int n);
    n = 0;
    while (sig(s) !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50)
      check({tag, " timeout"}, sig(s), 1);
  endtask

  task automatic apply_write(input logic [12:0] addr, input logic [3:0] len,
                             input logic [1:0] burst, input int nbeats,
                             input logic [1:0] exp_resp, input string tag);
    logic [12:0] a;
    int n;
    a = addr;
    @(negedge clk);
    bus.awvalid = 1'b1;
    bus.awaddr  = {19'h7A5A5, addr};
    bus.awlen   = len;
    bus.awburst = burst;
    bus.awsize  = 3'd1;
    wait_sig(0, {tag, " awready"}, n);
    @(posedge clk);
    #1 bus.awvalid = 1'b0;
    @(negedge clk);
    check({tag, " awready drop"}, bus.awready, 0);
    for (int i = 0; i < nbeats; i++) begin
      bus.wvalid = 1'b1;
      bus.wdata  = {48'hFFFF_0000_5A5A, wr_buf[i]};
      bus.wstrb  = 8'h00;
      bus.wlast  = (i == nbeats - 1);
      wait_sig(1, {tag, " wready"}, n);
      @(posedge clk);
      #1;
      if (i <= int'(len))
        model[int'(a)] = wr_buf[i];
      if (burst != 2'b00)
        a = a + 13'd1;
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      @(negedge clk);
    end
    check({tag, " wready low"}, bus.wready, 0);
    check({tag, " bvalid"}, bus.bvalid, 1);
    check({tag, " bresp"}, bus.bresp, exp_resp);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check({tag, " bvalid hold"}, bus.bvalid, 1);
    end
    bus.bready = 1'b1;
    @(posedge clk);
    #1 bus.bready = 1'b0;
    @(negedge clk);
    check({tag, " bvalid drop"}, bus.bvalid, 0);
    check({tag, " awready back"}, bus.awready, 1);
  endtask

  task automatic apply_read(input logic [12:0] addr, input logic [3:0] len,
                            input logic [1:0] burst, input bit chk_lat, input string tag);
    logic [12:0] a;
    logic [15:0] e;
    int n;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      exp_q.push_back(model[int'(a)]);
      if (burst != 2'b00)
        a = a + 13'd1;
    end
    @(negedge clk);
    bus.arvalid = 1'b1;
    bus.araddr  = {19'h05A5A, addr};
    bus.arlen   = len;
    bus.arburst = burst;
    bus.arsize  = 3'd1;
    wait_sig(3, {tag, " arready"}, n);
    @(posedge clk);
    #1 bus.arvalid = 1'b0;
    @(negedge clk);
    check({tag, " arready drop"}, bus.arready, 0);
    for (int i = 0; i <= int'(len); i++) begin
      wait_sig(4, {tag, " rvalid"}, n);
      if (chk_lat)
        check({tag, " beat latency"}, n, 1);
      e = exp_q.pop_front();
      check({tag, " rdata"}, bus.rdata, {48'h0, e});
      check({tag, " rlast"}, bus.rlast, (i == int'(len)));
      check({tag, " rresp"}, bus.rresp, 0);
      @(negedge clk);
      check({tag, " rvalid hold"}, bus.rvalid, 1);
      check({tag, " rdata hold"}, bus.rdata, {48'h0, e});
      bus.rready = 1'b1;
      @(posedge clk);
      #1 bus.rready = 1'b0;
      @(negedge clk);
      check({tag, " rvalid drop"}, bus.rvalid, 0);
    end
    check({tag, " arready back"}, bus.arready, 1);
  endtask

  // Directed sequence: reset, INCR/FIXED/WRAP bursts, early wlast, address wrap with a concurrent read.
  initial begin
    bus.awvalid = 0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.wvalid = 0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 0; bus.bready = 0;
    bus.arvalid = 0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.rready = 0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset awready", bus.awready, 1);
    check("reset arready", bus.arready, 1);
    check("reset wready", bus.wready, 0);
    check("reset bvalid", bus.bvalid, 0);
    check("reset rvalid", bus.rvalid, 0);
    check("reset rlast", bus.rlast, 0);
    check("reset bresp", bus.bresp, 0);
    check("reset rresp", bus.rresp, 0);
    check("reset rdata", bus.rdata, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post reset awready", bus.awready, 1);

    $display("[TB] INCR write/read at 0x0A");
    wr_buf[0] = 16'hABCD; wr_buf[1] = 16'hFDDF; wr_buf[2] = 16'hFAFA;
    apply_write(13'h000A, 4'd2, 2'b01, 3, 2'b00, "incr_wr");
    apply_read(13'h000A, 4'd2, 2'b01, 1'b1, "incr_rd");

    $display("[TB] FIXED write at 0x20");
    wr_buf[0] = 16'h5555; wr_buf[1] = 16'h6666;
    apply_write(13'h0020, 4'd1, 2'b01, 2, 2'b00, "pre_wr");
    wr_buf[0] = 16'h1111; wr_buf[1] = 16'h2222;
    apply_write(13'h0020, 4'd1, 2'b00, 2, 2'b00, "fixed_wr");
    apply_read(13'h0020, 4'd1, 2'b01, 1'b1, "fixed_rd");

    $display("[TB] early wlast");
    wr_buf[0] = 16'h3333; wr_buf[1] = 16'h4444;
    apply_write(13'h0040, 4'd3, 2'b01, 2, 2'b10, "early_wr");
    apply_read(13'h0040, 4'd1, 2'b01, 1'b1, "early_rd");

    $display("[TB] WRAP burst treated as INCR");
    wr_buf[0] = 16'h0BAD; wr_buf[1] = 16'hC0DE; wr_buf[2] = 16'hBEEF;
    apply_write(13'h0100, 4'd2, 2'b10, 3, 2'b00, "wrap_wr");
    apply_read(13'h0100, 4'd2, 2'b10, 1'b1, "wrap_rd");

    $display("[TB] address wrap with concurrent read");
    wr_buf[0] = 16'h7777; wr_buf[1] = 16'h8888;
    fork
      apply_write(13'h1FFF, 4'd1, 2'b01, 2, 2'b00, "conc_wr");
      apply_read(13'h000A, 4'd2, 2'b01, 1'b0, "conc_rd");
    join
    apply_read(13'h1FFF, 4'd1, 2'b01, 1'b1, "edge_rd");
    apply_read(13'h0000, 4'd0, 2'b00, 1'b1, "zero_rd");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/axi_main.md
# axi_main

AXI4 memory-mapped slave fronting an 8192×16-bit on-chip RAM. It carries the FIR block's host-side AXI write channels (AW/W/B) and read channels (AR/R) and stores or fetches one 16-bit word per beat. Independent write and read FSMs share one single-port RAM through an address/control multiplexer.

## Interface
- ADDR_W, 13: RAM word-address width (depth 2^ADDR_W).
- WORD_W, 16: RAM word width.
- AXI_AW, 32: AXI address width.
- AXI_DW, 64: AXI data width.
- Clocking: one clock; reset is asynchronous and active-low.
- a_clk  in  1  clock; all state changes on the rising edge.
- a_rst_n  in  1  asynchronous active-low reset.
- awvalid / awready  in / out  1  AW handshake.
- awaddr  in  32  word address; bits [12:0] are used.
- awlen  in  4  beats-1.
- awsize  in  3  accepted, ignored.
- awburst  in  2  00 = FIXED, 01 = INCR, 10 = WRAP; WRAP is treated as INCR.
- wvalid / wready  in / out  1  W handshake.
- wdata  in  64  bits [15:0] are written.
- wstrb  in  8  ignored; a full word is always written.
- wlast  in  1  last write beat.
- bvalid / bready  out / in  1  B handshake.
- bresp  out  2  00 OKAY, 10 SLVERR.
- arvalid / arready  in / out  1  AR handshake.
- araddr  in  32  word address; bits [12:0] are used.
- arlen  in  4  beats-1.
- arsize  in  3  ignored.
- arburst  in  2  same semantics as awburst.
- rvalid / rready  out / in  1  R handshake.
- rdata  out  64  {48'b0, word}.
- rlast  out  1  final read beat.
- rresp  out  2  always 00.

## Operation
- Write FSM states:
  - W_IDLE: awready = 1. On awvalid&&awready, capture addr[12:0], awlen, awburst; go to W_DATA.
  - W_DATA: wready = 1. Each wvalid&&wready beat writes wdata[15:0] to RAM[addr] at that edge and increments the beat counter. INCR/WRAP advance addr by 1 (8191 wraps to 0); FIXED holds addr. Beats beyond awlen+1 are accepted but not written. The beat carrying wlast ends the burst and moves the FSM to W_RESP.
  - W_RESP: bvalid = 1. bresp = OKAY if accepted beats equal awlen+1, else SLVERR. On bready, return to W_IDLE.
- Read FSM states:
  - R_IDLE: arready = 1. On handshake, capture addr, arlen, arburst and clear the beat counter; go to R_FETCH.
  - R_FETCH: drive addr to the RAM (synchronous read); go to R_DATA.
  - R_DATA: rvalid = 1. rdata and rlast (beat == arlen) are held stable until rready. On handshake: if rlast, go to R_IDLE; otherwise advance addr per burst type, increment the beat counter, and go to R_FETCH.
- RAM arbitration: a W_DATA write beat has priority. If it collides with R_FETCH, R_FETCH stays one extra cycle.
- RAM contents are not reset.
- Reset values:
  - Both FSMs go to IDLE, so awready = arready = 1.
  - wready, bvalid, rvalid and rlast are 0.
  - bresp, rresp and rdata are 0.
- Reset mid-burst aborts the burst. RAM words already written are kept.

## Timing
- AW accepted at edge E0: wready is high from E0 to the edge accepting the wlast beat. A beat accepted at edge Ek is visible in RAM after Ek.
- Last W beat accepted at edge En: bvalid is high after En and stays high until the bready edge.
- AR accepted at edge E0: rvalid is high after E1.
- Each subsequent beat arrives one cycle after the previous R handshake, giving a peak rate of one beat per 2 cycles.
- awready and arready drop the cycle after their handshake.
- Write and read bursts may be in flight concurrently.

## Structure
- Package axi_main_pkg holds:
  - ADDR_W, WORD_W, AXI_DW;
  - burst encodings;
  - RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10;
  - write and read state enums.
- Sub-module axi_main_ram: single-port 2^ADDR_W × WORD_W RAM with synchronous write and registered read.
- The two FSMs and the mux live in the top module.

## Test plan
- Reset: hold a_rst_n = 0 for 2 cycles → awready = arready = 1; wready, bvalid, rvalid, rlast = 0.
- INCR write: awaddr = 0x0A, awlen = 2, awburst = 01, then W beats 0xABCD, 0xFDDF, 0xFAFA with wlast on beat 3 → RAM[0x0A..0x0C] = ABCD, FDDF, FAFA; bvalid holds until bready is raised 2 cycles later; bresp = 00.
- INCR read: araddr = 0x0A, arlen = 2, rready raised one cycle after each rvalid → rdata = 0xABCD, 0xFDDF, 0xFAFA in order; rvalid holds until each rready; rlast only on the 3rd beat; rresp = 00.
- FIXED write: awaddr = 0x20, awlen = 1, awburst = 00, data 0x1111 then 0x2222 → RAM[0x20] = 0x2222 and RAM[0x21] is unchanged.
- Early wlast: awlen = 3 with wlast on beat 2 → bresp = 10; the FSM returns to W_IDLE.
- Wrap and concurrency: write at 0x1FFF with awlen = 1 → second word lands at 0x0000. In parallel, a read burst to 0x0A completes with correct data.
